// File: rtl/flash_adc_capture_ctrl_pkg.sv
// Shared definitions for the flash ADC capture path: default code width and
// the capture sequencer state encoding.
package flash_adc_pkg;
    localparam int CODE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;
endpackage

// File: rtl/flash_adc_capture_ctrl_sync_fifo.sv
// Pointer-based synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/flash_adc_capture_ctrl.sv
// Burst capture sequencer for the flash ADC: decimated sample strobes, latency
// alignment of the encoder output, and FIFO buffering onto a valid/ready stream.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for start with a non-zero burst length
//   ST_CAPTURE | issuing strobes every decim+1 cycles until the burst is out
//   ST_FLUSH   | PIPE_LAT cycles for in-flight codes to reach the FIFO
//   ST_DONE    | one-cycle done pulse, then back to idle
module flash_adc_capture_ctrl
    import flash_adc_pkg::*;
#(
    parameter int CODE_W   = CODE_W_DEF,
    parameter int DEPTH    = 16,
    parameter int PIPE_LAT = 1,
    parameter int LEN_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [3:0]        decim,
    input  logic [CODE_W-1:0] adc_code,
    output logic              sample_en,
    output logic [CODE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    cap_state_t          state_q, state_d;
    logic [LEN_W-1:0]    rem_cnt;
    logic [3:0]          decim_q, dec_cnt;
    logic [FW-1:0]       flush_cnt;
    logic [PIPE_LAT-1:0] pipe_q;
    logic                accept, tap;
    logic                fifo_full, fifo_empty;
    logic [CODE_W-1:0]   fifo_head;

    assign tap = pipe_q[PIPE_LAT-1];

    always_comb begin
        state_d   = state_q;
        sample_en = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start && burst_len != '0) begin
                    accept  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (dec_cnt == 4'd0) begin
                    sample_en = 1'b1;
                    if (rem_cnt == LEN_W'(1)) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_cnt   <= '0;
            decim_q   <= '0;
            dec_cnt   <= '0;
            flush_cnt <= '0;
            pipe_q    <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;

            // First strobe lands on the cycle right after acceptance.
            if (accept) begin
                rem_cnt <= burst_len;
                decim_q <= decim;
                dec_cnt <= 4'd0;
            end else if (state_q == ST_CAPTURE) begin
                if (sample_en) begin
                    rem_cnt <= rem_cnt - LEN_W'(1);
                    dec_cnt <= decim_q;
                end else begin
                    dec_cnt <= dec_cnt - 4'd1;
                end
            end

            if (state_q != ST_FLUSH)  flush_cnt <= FW'(PIPE_LAT - 1);
            else if (flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);

            pipe_q[0] <= sample_en;
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];

            if (accept)                overflow <= 1'b0;
            else if (tap && fifo_full) overflow <= 1'b1;
        end
    end

    sync_fifo #(.W(CODE_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tap),
        .wr_data (adc_code),
        .rd_en   (m_ready),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head : '0;
endmodule

// File: tb/tb_flash_adc_capture_ctrl.sv
// Directed and randomized bursts against a cycle-scheduled reference model of
// strobe times, write times and FIFO contents.
module tb_flash_adc_capture_ctrl;
    localparam int CODE_W   = 8;
    localparam int DEPTH    = 16;
    localparam int PIPE_LAT = 1;
    localparam int LEN_W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [3:0]        decim = '0;
    logic [CODE_W-1:0] adc_code = '0;
    logic              m_ready = 1'b0;
    logic              sample_en, m_valid, busy, done, overflow;
    logic [CODE_W-1:0] m_data;

    flash_adc_capture_ctrl #(
        .CODE_W(CODE_W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .decim     (decim),
        .adc_code  (adc_code),
        .sample_en (sample_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    bit ramp  = 1'b0;
    bit rand_ready = 1'b0;

    // Reference model: a burst is a list of strobe cycles; each strobe becomes
    // a FIFO write PIPE_LAT cycles later.
    logic [CODE_W-1:0] mq[$];
    int                wrq[$];
    bit                m_on  = 1'b0;
    bit                m_ovf = 1'b0;
    int                m_next, m_left, m_done, m_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit e_se, e_busy, e_done, wr, full;
        @(negedge clk);
        e_se   = m_on && (m_left > 0) && (cyc == m_next);
        e_busy = m_on;
        e_done = m_on && (cyc == m_done);
        chk("sample_en", 32'(sample_en), 32'(e_se));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("done",      32'(done),      32'(e_done));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("m_valid",   32'(m_valid),   32'(mq.size() > 0));
        chk("m_data",    32'(m_data),    32'((mq.size() > 0) ? mq[0] : '0));
        if (m_valid && m_ready) pops++;

        full = (mq.size() == DEPTH);
        wr   = (wrq.size() > 0) && (wrq[0] == cyc);
        if (wr) void'(wrq.pop_front());
        if (m_ready && mq.size() > 0) void'(mq.pop_front());
        if (wr) begin
            if (full) m_ovf = 1'b1;
            else      mq.push_back(adc_code);
        end
        if (e_se) begin
            wrq.push_back(cyc + PIPE_LAT);
            m_left--;
            m_next += m_step;
        end
        if (e_done) m_on = 1'b0;
        if (!e_busy && start && burst_len != '0) begin
            m_on   = 1'b1;
            m_ovf  = 1'b0;
            m_step = int'(decim) + 1;
            m_left = int'(burst_len);
            m_next = cyc + 1;
            m_done = cyc + 1 + (int'(burst_len) - 1) * m_step + PIPE_LAT + 1;
        end

        @(posedge clk);
        #1;
        cyc++;
        adc_code = ramp ? adc_code + CODE_W'(1) : CODE_W'($urandom);
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        wrq.delete();
        m_on  = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk("rst_sample_en", 32'(sample_en), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    task automatic burst(input int len, input int dcm);
        burst_len = LEN_W'(len);
        decim     = 4'(dcm);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        do_reset();
        run(2);

        // Ramp codes, back-to-back strobes, consumer always ready.
        ramp = 1'b1;
        m_ready = 1'b1;
        burst(4, 0);
        run(10);

        // Decimated strobes every third cycle.
        burst(3, 2);
        run(14);
        ramp = 1'b0;

        // Overrun the FIFO with the consumer stalled, then drain it.
        m_ready = 1'b0;
        burst(20, 0);
        run(25);
        chk("ovf_after_overrun", 32'(overflow), 32'd1);
        pops = 0;
        m_ready = 1'b1;
        run(20);
        chk("overrun_drain_count", 32'(pops), 32'd16);

        // Full FIFO with push and pop in the same cycle: the push is dropped.
        m_ready = 1'b0;
        burst(16, 0);
        run(22);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        burst(1, 0);
        run(PIPE_LAT);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        run(3);
        chk("ovf_push_pop_full", 32'(overflow), 32'd1);
        pops = 0;
        m_ready = 1'b1;
        run(20);
        chk("push_pop_drain_count", 32'(pops), 32'd15);

        // Reset after two of eight strobes, then a clean eight-sample burst.
        burst(8, 1);
        run(3);
        do_reset();
        run(4);
        burst(8, 1);
        run(22);

        // Start while busy and start with zero length are both ignored.
        burst(5, 0);
        step();
        start = 1'b1;
        burst_len = 8'd2;
        decim = 4'd3;
        run(2);
        start = 1'b0;
        run(8);
        burst_len = '0;
        start = 1'b1;
        run(3);
        start = 1'b0;
        run(2);
        chk("len0_idle_busy", 32'(busy), 32'd0);

        // Randomized bursts with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            burst($urandom_range(1, 12), $urandom_range(0, 3));
            run(70);
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        run(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
